// File: rtl/evm_pkg.sv
// evm_pkg: shared types and constants for the EVM tally controller
package evm_pkg;
  localparam int NUM_PARTIES = 4;
  typedef logic [1:0] party_t;
  typedef enum logic [2:0] {SETUP, OPEN, LOCK, SEALED, READOUT} state_t;
endpackage

// File: rtl/evm_cycle_timer.sv
// evm_cycle_timer: loadable down-counter; done is high on the final counted cycle
module evm_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] cnt;
  logic         run;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= value;
      run <= 1'b1;
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else cnt <= cnt - W'(1);
    end
  assign done = run && cnt == '0;
endmodule

// File: rtl/evm_tally_controller.sv
// evm_tally_controller: poll lifecycle FSM owning the per-party and total vote counters
module evm_tally_controller
  import evm_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int TOT_W       = 10,
  parameter int LOCKOUT_CYC = 4,
  parameter int HOLD_CYC    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             officer_ok,
  input  logic             open_poll,
  input  logic             seal_poll,
  input  logic             clear_req,
  input  logic             vote_valid,
  input  party_t           vote_party,
  input  logic             result_req,
  output logic             vote_ack,
  output logic             vote_rej,
  output logic             poll_open,
  output logic             poll_sealed,
  output logic [TOT_W-1:0] total_votes,
  output logic             result_valid,
  output party_t           result_party,
  output logic [CNT_W-1:0] result_count,
  output logic             overflow_flag
);
  localparam int MAXC = LOCKOUT_CYC > HOLD_CYC ? LOCKOUT_CYC : HOLD_CYC;
  localparam int TW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] LOCK_LD = TW'(LOCKOUT_CYC - 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYC - 1);
  state_t                             state;
  logic [NUM_PARTIES-1:0][CNT_W-1:0]  cnt;
  logic                               cnt_full, tot_full, accept, start_ro, next_party;
  logic                               tmr_load, tmr_done;
  logic [TW-1:0]                      tmr_val;
  assign cnt_full   = &cnt[vote_party];
  assign tot_full   = &total_votes;
  assign accept     = state == OPEN && vote_valid && !cnt_full;
  assign start_ro   = state == SEALED && result_req && officer_ok;
  assign next_party = state == READOUT && tmr_done && result_party != party_t'(NUM_PARTIES - 1);
  // LOCK and READOUT never overlap, so one timer serves both countdowns
  assign tmr_load = accept | start_ro | next_party;
  assign tmr_val  = accept ? LOCK_LD : HOLD_LD;
  evm_cycle_timer #(.W(TW)) u_tmr (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_val),
    .done  (tmr_done)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state         <= SETUP;
      cnt           <= '0;
      total_votes   <= '0;
      vote_ack      <= 1'b0;
      vote_rej      <= 1'b0;
      result_valid  <= 1'b0;
      result_party  <= '0;
      overflow_flag <= 1'b0;
    end else begin
      vote_ack <= accept;
      vote_rej <= vote_valid && !accept;
      case (state)
        SETUP: begin
          if (clear_req && officer_ok) begin
            cnt           <= '0;
            total_votes   <= '0;
            overflow_flag <= 1'b0;
          end
          if (open_poll && officer_ok) state <= OPEN;
        end
        OPEN:
          if (vote_valid) begin
            if (cnt_full) overflow_flag <= 1'b1;
            else begin
              cnt[vote_party] <= cnt[vote_party] + CNT_W'(1);
              if (tot_full) overflow_flag <= 1'b1;
              else total_votes <= total_votes + TOT_W'(1);
              state <= LOCK;
            end
          end else if (seal_poll && officer_ok) state <= SEALED;
        LOCK: if (tmr_done) state <= OPEN;
        SEALED:
          if (start_ro) begin
            state        <= READOUT;
            result_valid <= 1'b1;
            result_party <= '0;
          end
        READOUT:
          if (next_party) result_party <= result_party + party_t'(1);
          else if (tmr_done) begin
            state        <= SEALED;
            result_valid <= 1'b0;
          end
        default: state <= SETUP;
      endcase
    end
  assign poll_open    = state == OPEN || state == LOCK;
  assign poll_sealed  = state == SEALED || state == READOUT;
  assign result_count = result_valid ? cnt[result_party] : '0;
endmodule

// File: doc/evm_tally_controller.md
# evm_tally_controller

Vote-tally controller for the EVM. It sits downstream of the ballot-unit FSM, which emits one 2-bit party code per cast vote. The controller owns the four per-party vote counters and a total counter, and sequences the poll lifecycle: setup/clear, open, post-vote lockout, seal, and officer-triggered result readout. It is the only block that writes the tally registers.

## Interface
- CNT_W, 8: width of each per-party counter
- TOT_W, 10: width of the total-vote counter
- LOCKOUT_CYC, 4: cycles spent in LOCK after an accepted vote (≥1)
- HOLD_CYC, 8: cycles each party result is held during readout (≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- officer_ok  in  1  officer authenticated; qualifies open_poll, seal_poll, clear_req, result_req
- open_poll  in  1  pulse: open polling
- seal_poll  in  1  pulse: seal the machine
- clear_req  in  1  pulse: zero all counters (SETUP only)
- vote_valid  in  1  pulse from ballot FSM: one vote cast
- vote_party  in  2  party code, valid with vote_valid
- result_req  in  1  pulse: start result readout
- vote_ack  out  1  one-cycle pulse: vote counted
- vote_rej  out  1  one-cycle pulse: vote dropped
- poll_open  out  1  high in OPEN and LOCK
- poll_sealed  out  1  high in SEALED and READOUT
- total_votes  out  TOT_W  live total count
- result_valid  out  1  high while result_party/result_count are meaningful
- result_party  out  2  party being displayed
- result_count  out  CNT_W  that party's count
- overflow_flag  out  1  sticky; set when any counter saturates

## Operation
- States: SETUP, OPEN, LOCK, SEALED, READOUT.
- Reset: state SETUP; all counters 0; every output 0.
- SETUP
  - clear_req & officer_ok zeroes all counters and overflow_flag.
  - open_poll & officer_ok -> OPEN.
  - vote_valid -> vote_rej.
- OPEN
  - vote_valid increments counter[vote_party] and total, pulses vote_ack, -> LOCK.
  - seal_poll & officer_ok with no vote_valid -> SEALED.
  - Same-cycle vote_valid and seal: vote counted first, -> LOCK, seal ignored. The officer re-issues the seal.
- LOCK: vote_valid -> vote_rej (one voter per window). Counts down LOCKOUT_CYC cycles, then -> OPEN. Seal in LOCK is ignored.
- SEALED
  - vote_valid -> vote_rej.
  - result_req & officer_ok -> READOUT. Party index starts at 0.
  - clear_req and open_poll are ignored; a sealed machine never reopens without reset.
- READOUT
  - result_valid=1. Presents party 0, 1, 2, 3 in order, HOLD_CYC cycles each, then -> SEALED with result_valid=0.
  - result_req during READOUT is ignored.
- Saturation
  - A per-party counter at 2^CNT_W−1 does not wrap.
  - A vote to that party gives vote_rej, sets overflow_flag, and stays in OPEN.
  - A total at max also saturates.
- Commands without officer_ok have no effect.

## Timing
- Inputs are sampled on the rising clk edge.
- vote_ack/vote_rej assert the cycle after the sampled vote_valid and last exactly 1 cycle.
- Counter and total update on that same edge.
- LOCK occupancy is exactly LOCKOUT_CYC cycles; a vote sampled on the first OPEN cycle after LOCK is accepted.
- READOUT: result_valid rises the cycle after result_req is sampled and stays high for 4×HOLD_CYC cycles. result_party changes every HOLD_CYC cycles.
- Reset mid-operation: immediate return to the reset state; counters are lost.

## Structure
- Package evm_pkg:
  - state enum
  - NUM_PARTIES=4
  - party-code type (2-bit)
- Sub-module evm_cycle_timer: loadable down-counter with a done pulse. It is shared between the LOCK countdown and the READOUT hold, since the two states are exclusive.

## Test plan
- Reset, clear, open, votes on parties 2,0,2,3 spaced > LOCKOUT_CYC -> four vote_ack pulses; counts 1,0,2,1; total_votes=4.
- Two vote_valid pulses 1 cycle apart in OPEN -> first gives vote_ack, second gives vote_rej; total increments by 1.
- vote_valid and seal_poll in the same cycle -> vote counted, LOCK entered, poll_sealed stays 0. A later seal -> poll_sealed=1.
- CNT_W=2, four votes to party 1 -> counter stays 3; 4th vote gives vote_rej; overflow_flag=1.
- Sealed with counts 5,3,0,7 and result_req -> result_party 0..3 each HOLD_CYC cycles with counts 5,3,0,7, then result_valid=0.
- open_poll/clear_req with officer_ok=0, and reset asserted mid-READOUT -> no state change; the reset case returns to SETUP with all outputs 0.
